// File: rtl/decode_unit.sv
// Decode stage of the multi-cycle Pillar core: registers instruction fields, immediate and operands.
// Optional feature: define DECODE_RVE_EN for a 16-entry register file with index-range checking.
module decode_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      stage_i,
    input  logic [31:0]     ir_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            valid_o,
    output logic [6:0]      opcode_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [4:0]      rs1_idx_o,
    output logic [4:0]      rs2_idx_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

`ifdef DECODE_RVE_EN
    localparam int unsigned NR  = (NREGS > 16) ? 16 : NREGS;
    localparam bit          RVE = 1'b1;
`else
    localparam int unsigned NR  = NREGS;
    localparam bit          RVE = 1'b0;
`endif
    localparam int unsigned AW   = $clog2(NR);
    localparam logic [5:0]  NR_W = 6'(NR);

    localparam logic [2:0] STAGE_FETCH  = 3'd1;
    localparam logic [2:0] STAGE_DECODE = 3'd2;

    logic [XLEN-1:0] r_rf [NR];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_we;
    logic        w_rs1_ok;
    logic        w_rs2_ok;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [31:0] w_imm32;
    logic        w_legal_op;
    logic        w_use_rd;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_range_bad;
    logic        w_illegal;

    assign w_opcode = ir_i[6:0];
    assign w_rd     = ir_i[11:7];
    assign w_rs1    = ir_i[19:15];
    assign w_rs2    = ir_i[24:20];

    // Index 0 and out-of-range indices are never stored and always read as zero.
    assign w_we     = wb_en_i && (wb_rd_i != '0) && ({1'b0, wb_rd_i} < NR_W);
    assign w_rs1_ok = (w_rs1 != '0) && ({1'b0, w_rs1} < NR_W);
    assign w_rs2_ok = (w_rs2 != '0) && ({1'b0, w_rs2} < NR_W);

    // Write-first: a same-edge write to a source register is forwarded to the operand.
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (w_rs1_ok) w_rs1_data = r_rf[w_rs1[AW-1:0]];
        if (w_rs2_ok) w_rs2_data = r_rf[w_rs2[AW-1:0]];
        if (w_we && (wb_rd_i == w_rs1)) w_rs1_data = wb_data_i;
        if (w_we && (wb_rd_i == w_rs2)) w_rs2_data = wb_data_i;
    end

    always_comb begin
        w_imm32    = '0;
        w_legal_op = 1'b1;
        w_use_rd   = 1'b0;
        w_use_rs1  = 1'b0;
        w_use_rs2  = 1'b0;
        case (w_opcode)
            7'h03, 7'h13, 7'h67, 7'h73: begin
                w_imm32   = {{20{ir_i[31]}}, ir_i[31:20]};
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
            end
            7'h23: begin
                w_imm32   = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            7'h63: begin
                w_imm32   = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            7'h37, 7'h17: begin
                w_imm32  = {ir_i[31:12], 12'b0};
                w_use_rd = 1'b1;
            end
            7'h6F: begin
                w_imm32  = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
                w_use_rd = 1'b1;
            end
            7'h33: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            default: w_legal_op = 1'b0;
        endcase
    end

    assign w_range_bad = RVE && ((w_use_rd && w_rd[4]) || (w_use_rs1 && w_rs1[4])
                                 || (w_use_rs2 && w_rs2[4]));
    assign w_illegal   = !w_legal_op || (ir_i[1:0] != 2'b11) || w_range_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NR; i++) r_rf[i] <= '0;
        end else if (w_we) begin
            r_rf[wb_rd_i[AW-1:0]] <= wb_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o    <= 1'b0;
            opcode_o   <= '0;
            rd_o       <= '0;
            funct3_o   <= '0;
            funct7_o   <= '0;
            rs1_idx_o  <= '0;
            rs2_idx_o  <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            illegal_o  <= 1'b0;
        end else if (stage_i == STAGE_DECODE) begin
            valid_o    <= 1'b1;
            opcode_o   <= w_opcode;
            rd_o       <= w_rd;
            funct3_o   <= ir_i[14:12];
            funct7_o   <= ir_i[31:25];
            rs1_idx_o  <= w_rs1;
            rs2_idx_o  <= w_rs2;
            rs1_data_o <= w_rs1_data;
            rs2_data_o <= w_rs2_data;
            imm_o      <= XLEN'(signed'(w_imm32));
            illegal_o  <= w_illegal;
        end else if (stage_i == STAGE_FETCH) begin
            valid_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: reference model plus directed literal checks.
module tb_decode_unit;

`ifdef DECODE_RVE_EN
    localparam bit RVE = 1'b1;
`else
    localparam bit RVE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  stage = 3'd0;
    logic [31:0] ir = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    logic        valid_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [4:0]  rs1_idx_o;
    logic [4:0]  rs2_idx_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    decode_unit dut (
        .clk(clk), .reset(reset), .stage_i(stage), .ir_i(ir),
        .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .valid_o(valid_o), .opcode_o(opcode_o), .rd_o(rd_o),
        .funct3_o(funct3_o), .funct7_o(funct7_o),
        .rs1_idx_o(rs1_idx_o), .rs2_idx_o(rs2_idx_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register array plus expected output record.
    logic [31:0] m_rf [32];
    logic        e_valid;
    logic [31:0] e_ir;
    logic [31:0] e_rs1, e_rs2, e_imm;
    logic        e_ill;

    function automatic logic [31:0] m_imm(input logic [31:0] x);
        int v;
        v = 0;
        case (x[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: v = int'($signed(x) >>> 20);
            7'h23: v = (int'($signed(x) >>> 20) & ~32'h1F) | int'(x[11:7]);
            7'h63: v = (x[31] ? -4096 : 0) + int'(x[7]) * 2048 + int'(x[30:25]) * 32
                       + int'(x[11:8]) * 2;
            7'h37, 7'h17: v = int'(x & 32'hFFFF_F000);
            7'h6F: v = (x[31] ? -(1 << 20) : 0) + int'(x[19:12]) * 4096
                       + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic m_ill(input logic [31:0] x);
        logic rdu, r1u, r2u;
        rdu = 1'b0; r1u = 1'b0; r2u = 1'b0;
        case (x[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin rdu = 1; r1u = 1; end
            7'h23, 7'h63: begin r1u = 1; r2u = 1; end
            7'h37, 7'h17, 7'h6F: rdu = 1;
            7'h33: begin rdu = 1; r1u = 1; r2u = 1; end
            default: return 1'b1;
        endcase
        if (x[1:0] != 2'b11) return 1'b1;
        return RVE && ((rdu && x[11]) || (r1u && x[19]) || (r2u && x[24]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (RVE && idx[4]) return '0;
        return m_rf[idx];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            e_valid = 0; e_ir = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_ill = 0;
        end else begin
            if (wb_en && wb_rd != 0 && !(RVE && wb_rd[4])) m_rf[wb_rd] = wb_data;
            if (stage == 3'd2) begin
                e_valid = 1;
                e_ir    = ir;
                e_rs1   = m_read(ir[19:15]);
                e_rs2   = m_read(ir[24:20]);
                e_imm   = m_imm(ir);
                e_ill   = m_ill(ir);
            end else if (stage == 3'd1) begin
                e_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("valid",   32'(valid_o),    32'(e_valid));
            chk("opcode",  32'(opcode_o),   32'(e_ir[6:0]));
            chk("rd",      32'(rd_o),       32'(e_ir[11:7]));
            chk("funct3",  32'(funct3_o),   32'(e_ir[14:12]));
            chk("funct7",  32'(funct7_o),   32'(e_ir[31:25]));
            chk("rs1_idx", 32'(rs1_idx_o),  32'(e_ir[19:15]));
            chk("rs2_idx", 32'(rs2_idx_o),  32'(e_ir[24:20]));
            chk("rs1_data", rs1_data_o, e_rs1);
            chk("rs2_data", rs2_data_o, e_rs2);
            chk("imm",      imm_o,      e_imm);
            chk("illegal", 32'(illegal_o),  32'(e_ill));
        end
    end

    task automatic cyc(input logic rst, input logic [2:0] st, input logic [31:0] i,
                       input logic we, input logic [4:0] r, input logic [31:0] d);
        @(negedge clk);
        reset = rst; stage = st; ir = i; wb_en = we; wb_rd = r; wb_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] i);
        cyc(1'b0, 3'd2, i, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        cyc(1'b0, 3'd4, 32'h0, 1'b1, r, d);
    endtask

    task automatic idle(input logic [2:0] st);
        cyc(1'b0, st, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h12};

    initial begin
        cyc(1'b1, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc(1'b1, 3'd2, 32'h0050_0093, 1'b1, 5'd1, 32'h1);
        started = 1'b1;
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_imm",   imm_o,        32'h0);
        chk("rst_op",    32'(opcode_o), 32'h0);

        cap(32'h0050_0093);
        chk("addi_valid", 32'(valid_o),   32'h1);
        chk("addi_op",    32'(opcode_o),  32'h13);
        chk("addi_rd",    32'(rd_o),      32'h1);
        chk("addi_rs1",   rs1_data_o,     32'h0);
        chk("addi_imm",   imm_o,          32'h5);
        chk("addi_ill",   32'(illegal_o), 32'h0);
        idle(3'd3);
        chk("hold_valid", 32'(valid_o), 32'h1);
        idle(3'd1);
        chk("fetch_valid", 32'(valid_o), 32'h0);
        chk("fetch_op",    32'(opcode_o), 32'h13);

        wb(5'd1, 32'h0000_0100);
        cyc(1'b0, 3'd0, 32'h0, 1'b1, 5'd2, 32'h0000_ABCD);
        cap(32'hFE20_AE23);
        chk("sw_rs1", rs1_data_o, 32'h100);
        chk("sw_rs2", rs2_data_o, 32'hABCD);
        chk("sw_imm", imm_o,      32'hFFFF_FFFC);
        chk("sw_f3",  32'(funct3_o), 32'h2);

        idle(3'd1);
        cap(32'h1234_52B7);
        chk("lui_imm", imm_o,       32'h1234_5000);
        chk("lui_rd",  32'(rd_o),   32'h5);

        idle(3'd1);
        cyc(1'b0, 3'd2, 32'h0031_8233, 1'b1, 5'd3, 32'hDEAD_BEEF);
        chk("byp_rs1", rs1_data_o, 32'hDEAD_BEEF);
        chk("byp_rs2", rs2_data_o, 32'hDEAD_BEEF);

        cap(32'h0020_8463);
        chk("beq_imm", imm_o, 32'h0000_0008);
        cap(32'hFFFF_F0EF);
        chk("jal_imm", imm_o, 32'hFFFF_FFFE);

        cap(32'h0000_007F);
        chk("ill_7f", 32'(illegal_o), 32'h1);
        wb(5'd0, 32'hFFFF_FFFF);
        cap(32'h0050_0093);
        chk("x0_rs1", rs1_data_o, 32'h0);

        cap(32'h0050_0093);
        cyc(1'b1, 3'd3, 32'h0, 1'b1, 5'd6, 32'h55);
        chk("rst3_valid", 32'(valid_o), 32'h0);
        chk("rst3_imm",   imm_o,        32'h0);
        cap(32'h0000_8293);
        chk("rst_x1", rs1_data_o, 32'h0);

        cap(32'h0100_0093);
        chk("rve_legal", 32'(illegal_o), 32'h0);
        cap(32'h0000_0893);
        chk("rd17_ill", 32'(illegal_o), RVE ? 32'h1 : 32'h0);
        wb(5'd17, 32'h1717_1717);
        cap(32'h0008_8093);
        chk("x17_rd", rs1_data_o, RVE ? 32'h0 : 32'h1717_1717);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] rir;
            rir = ($urandom() & 32'hFFFF_FF80) | 32'(ops[$urandom_range(0, 11)]);
            cyc(($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)), rir,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
        end
        idle(3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
